// File: rtl/pc_sequencer_if.sv
// Instruction-fetch bus between the PC sequencer and the instruction ROM.
// The sequencer is the master: it issues the request and address, and the ROM answers with ready.
interface pc_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;

  modport master (output imem_req, imem_addr, input imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC control, branch/jump/jal/jr/ret target selection,
// and a circular return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                       MAX10_CLK1_50,
  input  logic                       reset,
  pc_sequencer_if.master             imem,
  output logic                       instr_valid,
  input  logic                       stall,
  input  logic [2:0]                 br_cond,
  input  logic                       zero,
  input  logic                       less,
  input  logic [PC_W-1:0]            imm,
  input  logic                       jump,
  input  logic                       jal,
  input  logic                       jr,
  input  logic                       ret,
  input  logic [PC_W-1:0]            jump_addr,
  input  logic [PC_W-1:0]            jr_target,
  output logic [PC_W-1:0]            link_addr,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top;
  logic [PC_W-1:0] ras_top_val;
  logic            br_taken;
  logic            ras_empty;
  logic            ras_full;
  logic            advance;
  logic            do_push;
  logic            do_pop;

  assign pc_inc         = pc + PC_W'(1);
  assign link_addr      = pc_inc;
  assign imem.imem_addr = pc;
  assign ras_top_val    = ras_mem[ras_top];
  assign ras_empty      = (ras_count == '0);
  assign ras_full       = (ras_count == CNT_W'(RAS_DEPTH));

  // jr overrides everything on the stack; a simultaneous jal+ret is treated as a plain ret.
  assign advance = (state == EXEC) && !stall;
  assign do_push = advance && jal && !jr && !ret;
  assign do_pop  = advance && ret && !jr;

  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      3'd1:    br_taken = zero;
      3'd2:    br_taken = !zero;
      3'd3:    br_taken = less;
      3'd4:    br_taken = !less;
      3'd5:    br_taken = zero | less;
      3'd6:    br_taken = !zero && !less;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_inc;
    if (jr) begin
      next_pc = jr_target;
    end else if (ret) begin
      next_pc = ras_empty ? pc_inc : ras_top_val;
    end else if (jump || jal) begin
      next_pc = jump_addr;
    end else if (br_taken) begin
      next_pc = pc_inc + imm;
    end
  end

  // A push always lands above the current top, so a full stack silently recycles its oldest slot.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (do_push) begin
      ras_mem[ras_top + PTR_W'(1)] <= pc_inc;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= PC_W'(RESET_PC);
      imem.imem_req <= 1'b0;
      instr_valid   <= 1'b0;
      ras_top       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state         <= FETCH;
          imem.imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ready) begin
            state         <= EXEC;
            imem.imem_req <= 1'b0;
            instr_valid   <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            state         <= FETCH;
            pc            <= next_pc;
            imem.imem_req <= 1'b1;
            instr_valid   <= 1'b0;
            if (do_push) begin
              ras_top <= ras_top + PTR_W'(1);
              if (ras_full) begin
                ras_overflow <= 1'b1;
              end else begin
                ras_count <= ras_count + CNT_W'(1);
              end
            end else if (do_pop) begin
              if (ras_empty) begin
                ras_underflow <= 1'b1;
              end else begin
                ras_top   <= ras_top - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state         <= IDLE;
          imem.imem_req <= 1'b0;
          instr_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter/instruction-address width.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-004 SHALL use one clock and asynchronous active-low reset: MAX10_CLK1_50 input 1 (clock); reset input 1 (active-low; async assert, sync deassert by caller).
REQ-005 SHALL have ports (name direction width meaning):
- imem_req  output  1  fetch request to instruction ROM
- imem_addr  output  PC_W  fetch address (= current pc)
- imem_ready  input  1  ROM has returned instruction for imem_addr
- instr_valid  output  1  instruction is valid; decode may act
- stall  input  1  hold current instruction in EXEC
- br_cond  input  3  0 none, 1 eq, 2 ne, 3 lt, 4 ge, 5 le, 6 gt, 7 none
- zero, less  input  1 each  ALU flags for current instruction
- imm  input  PC_W  branch offset, two's complement
- jump, jal, jr, ret  input  1 each  control from decoder
- jump_addr  input  PC_W  absolute jump/jal target
- jr_target  input  PC_W  register-sourced target
- link_addr  output  PC_W  pc+1, value written to return register by jal
- ras_count  output  clog2(RAS_DEPTH)+1  live stack entries
- ras_overflow, ras_underflow  output  1 each  sticky error flags

Function
REQ-006 SHALL implement FSM IDLE -> FETCH -> EXEC -> FETCH ...; IDLE left unconditionally one cycle after reset release.
REQ-007 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; FSM SHALL stay in FETCH until imem_ready=1, then enter EXEC on the next edge.
REQ-008 In EXEC, instr_valid SHALL be 1 and imem_req 0; control inputs SHALL be sampled only in EXEC.
REQ-009 stall=1 in EXEC SHALL hold state, pc and RAS unchanged; instr_valid stays 1.
REQ-010 On leaving EXEC (stall=0), pc SHALL load next_pc and FSM SHALL enter FETCH; one instruction = minimum 2 cycles.
REQ-011 next_pc priority: jr -> jr_target; else ret -> RAS top; else jump or jal -> jump_addr; else branch taken -> pc+1+imm; else pc+1.
REQ-012 Branch taken conditions: eq zero; ne !zero; lt less; ge !less; le zero|less; gt !zero&!less; codes 0/7 never taken.
REQ-013 All pc arithmetic SHALL be modulo 2^PC_W (pc = all-ones, next = 0).
REQ-014 link_addr SHALL equal pc+1 combinationally at all times.
REQ-015 jal (without jr/ret) in EXEC exit SHALL push pc+1; when full, oldest entry SHALL be discarded, ras_count stays RAS_DEPTH, ras_overflow sets.
REQ-016 ret (without jr) in EXEC exit SHALL pop; when empty, next_pc SHALL be pc+1, ras_count stays 0, ras_underflow sets.
REQ-017 jal and ret both asserted SHALL behave as ret only (pop, no push); jr suppresses all RAS activity.
REQ-018 Stack SHALL be circular storage with top pointer; no push/pop while stall=1 or outside EXEC.
REQ-019 Control inputs in IDLE/FETCH SHALL be ignored.

Reset
REQ-020 reset=0 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, ras_count=0, ras_overflow=0, ras_underflow=0; RAS contents don't-care.
REQ-021 Reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction with no pc or RAS update.

Verification
REQ-022 Release reset, imem_ready tied 1, no control -> imem_addr 0,1,2,3 in successive FETCH cycles, instr_valid every second cycle.
REQ-023 pc=5, br_cond=ne, zero=0, imm=-3 -> next fetch at 3; same with zero=1 -> fetch at 6.
REQ-024 jal at pc=10, jump_addr=40 -> fetch 40, ras_count 1; ret at pc=41 -> fetch 11, ras_count 0.
REQ-025 Five nested jals (RAS_DEPTH=4) -> ras_count 4, ras_overflow 1; four rets return to the last four link addresses; fifth ret -> pc+1, ras_underflow 1.
REQ-026 imem_ready held 0 for 3 cycles, stall held 1 for 2 cycles in EXEC -> pc, imem_addr and ras_count frozen, then normal advance.
REQ-027 pc=255, PC_W=8, no control -> next fetch 0; reset pulsed during EXEC with jal -> pc=RESET_PC, ras_count 0.
